bcd_down_counter: RTL and testbench
===================================

// Module: bcd_down_counter
//
// PURPOSE
//   Multi-digit BCD countdown timer: the decrementing counterpart of the BCD up-counter.
//   Loads a BCD start value, counts down one step per clock while running, and exposes
//   per-digit borrow enables. Raises a one-cycle done pulse when the count reaches 0000.
//   Sits beside the up-counter in timer/stopwatch datapaths and drives the same 7-seg/BCD consumers.
//
// PARAMETERS
//   DIGITS   4   number of BCD digits; q width = 4*DIGITS; legal range 2..8
//
// PORTS
//   clk       in   1          clock, all state updates on rising edge
//   reset     in   1          reset, synchronous, active-high
//   load      in   1          capture load_val into q (and reload reg); highest priority after reset
//   load_val  in   4*DIGITS   BCD start value; any digit >9 is clamped to 9 on capture
//   start     in   1          begin counting (IDLE only)
//   stop      in   1          halt counting, q holds (RUN/DONE)
//   q         out  4*DIGITS   current BCD count, digit 0 = q[3:0]
//   brw       out  DIGITS-1   brw[i] (index 1..DIGITS-1): digit i decrements this cycle (combinational)
//   busy      out  1          1 while state==RUN
//   done      out  1          1-cycle pulse, high while state==DONE
//
// BEHAVIOUR
//   - Reset: q=0, state=IDLE, busy=0, done=0, reload reg=0. Reset mid-count aborts with no done pulse.
//   - FSM states: IDLE, RUN, DONE. Registered; busy/done decoded from state.
//   - Priority per cycle: reset > load > stop > start/count.
//   - load (any state): q <= clamp(load_val), reload <= clamp(load_val), state <= IDLE.
//   - IDLE: start & q!=0 -> RUN (first decrement on the following edge); start & q==0 -> DONE.
//   - RUN: q decrements by 1 (BCD) each edge. Digit 0 always steps; digit i steps iff digits 0..i-1 are all 0.
//     Stepping digit: 0 -> 9 (borrow), else d-1. Non-stepping digits hold.
//   - RUN with q==1 (BCD ...0001): q <= 0, state <= DONE. done high in the cycle where q first reads 0.
//   - RUN & stop -> IDLE, q holds. Next start resumes from held value.
//   - DONE -> IDLE next edge (one-cycle done pulse); q stays 0. stop in DONE -> IDLE.
//   - brw[i] = (state==RUN) & (q[4i-1:0]==0); brw is 0 in IDLE/DONE.
//   - Count never wraps below 0000; q never holds a non-BCD digit.
//   - start while RUN or DONE ignored; load during RUN restarts from IDLE with no done pulse.
//
// CONFIGURATION
//   BCD_DOWN_AUTO_RELOAD_EN
//     defined: DONE -> RUN with q <= reload (periodic timer); done still pulses 1 cycle per period;
//              period = reload+1 cycles; reload==0 -> DONE -> IDLE as without macro; stop in DONE -> IDLE, q=0.
//     undefined: reload register not built; DONE -> IDLE always.
//
// TESTING
//   1. reset 3 cycles -> q=0000, busy=0, done=0, brw=000.
//   2. load 0012, start -> q: 0011,0010,0009 (brw[1]=1 on the 0010 cycle),...,0000; done high exactly 1 cycle at 0000, busy drops.
//   3. load 1000, start -> next q=0999 with brw=111 in the preceding cycle; stop after 5 steps -> q holds 0995; start -> resumes 0994.
//   4. load 9F3A -> q=9939 (clamped); load 0000, start -> done pulses next cycle, busy never asserted.
//   5. load 0003, start, reset asserted when q=0002 -> q=0000, IDLE, no done pulse; load+start same cycle -> load wins, IDLE.
//   6. BCD_DOWN_AUTO_RELOAD_EN: load 0002, start -> q 0002,0001,0000,0002,0001,0000...; done every 3 cycles; stop -> IDLE.

Source files
------------

// File: rtl/bcd_down_counter.sv
// rtl/bcd_down_counter.sv - multi-digit BCD countdown timer with per-digit borrow enables
// Optional periodic reload: define BCD_DOWN_AUTO_RELOAD_EN.
module bcd_down_counter #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  stop,
  output logic [4*DIGITS-1:0]   q,
  output logic [DIGITS-1:1]     brw,
  output logic                  busy,
  output logic                  done
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   q_nxt, q_dec, load_clamped;
  logic [DIGITS-1:0] step;
  logic           q_zero, q_one;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
  logic [W-1:0]   reload, reload_nxt;
`endif

  // Digit i steps only when every lower digit is already 0.
  always_comb begin
    load_clamped = '0;
    q_dec        = '0;
    step         = '0;
    step[0]      = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      load_clamped[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
      if (i > 0)
        step[i] = step[i-1] & (q[4*(i-1) +: 4] == 4'd0);
      if (step[i])
        q_dec[4*i +: 4] = (q[4*i +: 4] == 4'd0) ? 4'd9 : q[4*i +: 4] - 4'd1;
      else
        q_dec[4*i +: 4] = q[4*i +: 4];
    end
  end

  assign q_zero = (q == '0);
  assign q_one  = (q == W'(1));

  always_comb begin
    brw = '0;
    for (int i = 1; i < DIGITS; i++)
      brw[i] = (state == RUN) & step[i];
  end

  always_comb begin
    state_nxt  = state;
    q_nxt      = q;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
    reload_nxt = reload;
`endif
    if (load) begin
      q_nxt     = load_clamped;
      state_nxt = IDLE;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
      reload_nxt = load_clamped;
`endif
    end else if (stop) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start)
            state_nxt = q_zero ? DONE : RUN;
        end
        RUN: begin
          // Reaching zero ends the run; the count never wraps below 0000.
          if (q_zero || q_one) begin
            q_nxt     = '0;
            state_nxt = DONE;
          end else begin
            q_nxt = q_dec;
          end
        end
        DONE: begin
`ifdef BCD_DOWN_AUTO_RELOAD_EN
          if (reload != '0) begin
            q_nxt     = reload;
            state_nxt = RUN;
          end else begin
            state_nxt = IDLE;
          end
`else
          state_nxt = IDLE;
`endif
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      q     <= '0;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
      reload <= '0;
`endif
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
      reload <= reload_nxt;
`endif
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_bcd_down_counter.sv
// tb/tb_bcd_down_counter.sv - scoreboard bench for bcd_down_counter
// Expectations adapt to BCD_DOWN_AUTO_RELOAD_EN when it is defined.
module tb_bcd_down_counter;

  localparam int D = 4;
  localparam int W = 4 * D;
  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_DONE = 2;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           load = 1'b0;
  logic           start = 1'b0;
  logic           stop = 1'b0;
  logic [W-1:0]   load_val = '0;
  logic [W-1:0]   q;
  logic [D-1:1]   brw;
  logic           busy, done;

  typedef struct packed {
    logic [W-1:0] q;
    logic         busy;
    logic         done;
    logic [D-1:1] brw;
  } exp_t;

  typedef struct {
    logic         rst, ld, st, sp;
    logic [W-1:0] val;
    exp_t         e;
  } stim_t;

  exp_t  sb[$];
  stim_t plan[$];
  exp_t  e;
  int    n_pass = 0;
  int    n_total = 0;

  bcd_down_counter #(.DIGITS(D)) dut (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .q(q), .brw(brw), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] to_bcd(int n);
    logic [W-1:0] r = '0;
    int p = 1;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'((n / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Expected outputs from the decimal count value and state.
  function automatic exp_t exp_of(int n, int st);
    exp_t x;
    int p = 1;
    x.q    = to_bcd(n);
    x.busy = (st == S_RUN);
    x.done = (st == S_DONE);
    x.brw  = '0;
    for (int i = 1; i < D; i++) begin
      p = p * 10;
      if (st == S_RUN) x.brw[i] = ((n % p) == 0);
    end
    return x;
  endfunction

  function automatic stim_t mk(logic rst, logic ld, logic st, logic sp, logic [W-1:0] v, exp_t x);
    stim_t s;
    s.rst = rst; s.ld = ld; s.st = st; s.sp = sp; s.val = v; s.e = x;
    return s;
  endfunction

  task automatic drive(stim_t s);
    reset = s.rst; load = s.ld; start = s.st; stop = s.sp; load_val = s.val;
    sb.push_back(s.e);
  endtask

  task automatic test_reset();
    plan.delete();
    plan.push_back(mk(1, 0, 0, 0, '0, exp_of(0, S_IDLE)));
    plan.push_back(mk(1, 0, 0, 0, '0, exp_of(0, S_IDLE)));
    plan.push_back(mk(1, 1, 1, 0, 16'h5555, exp_of(0, S_IDLE)));
    foreach (plan[k]) begin
      drive(plan[k]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_total++;
      if ({q, busy, done, brw} === e) n_pass++;
      else $display("FAIL reset[%0d]: got q=%h busy=%b done=%b brw=%b, want q=%h busy=%b done=%b brw=%b",
                    k, q, busy, done, brw, e.q, e.busy, e.done, e.brw);
    end
  endtask

  task automatic test_count();
    plan.delete();
    plan.push_back(mk(0, 1, 0, 0, 16'h0012, exp_of(12, S_IDLE)));
    plan.push_back(mk(0, 0, 1, 0, '0, exp_of(12, S_RUN)));
    for (int n = 11; n >= 1; n--) plan.push_back(mk(0, 0, 0, 0, '0, exp_of(n, S_RUN)));
    plan.push_back(mk(0, 0, 0, 0, '0, exp_of(0, S_DONE)));
    plan.push_back(mk(0, 0, 0, 0, '0, AR ? exp_of(12, S_RUN) : exp_of(0, S_IDLE)));
    plan.push_back(mk(0, 0, 0, 1, '0, AR ? exp_of(12, S_IDLE) : exp_of(0, S_IDLE)));
    foreach (plan[k]) begin
      drive(plan[k]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_total++;
      if ({q, busy, done, brw} === e) n_pass++;
      else $display("FAIL count[%0d]: got q=%h busy=%b done=%b brw=%b, want q=%h busy=%b done=%b brw=%b",
                    k, q, busy, done, brw, e.q, e.busy, e.done, e.brw);
    end
  endtask

  task automatic test_borrow_stop();
    plan.delete();
    plan.push_back(mk(0, 1, 0, 0, 16'h1000, exp_of(1000, S_IDLE)));
    plan.push_back(mk(0, 0, 1, 0, '0, exp_of(1000, S_RUN)));
    for (int n = 999; n >= 995; n--) plan.push_back(mk(0, 0, 0, 0, '0, exp_of(n, S_RUN)));
    plan.push_back(mk(0, 0, 0, 1, '0, exp_of(995, S_IDLE)));
    plan.push_back(mk(0, 0, 0, 0, '0, exp_of(995, S_IDLE)));
    plan.push_back(mk(0, 0, 1, 0, '0, exp_of(995, S_RUN)));
    plan.push_back(mk(0, 0, 1, 0, '0, exp_of(994, S_RUN)));
    plan.push_back(mk(0, 0, 0, 1, '0, exp_of(994, S_IDLE)));
    foreach (plan[k]) begin
      drive(plan[k]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_total++;
      if ({q, busy, done, brw} === e) n_pass++;
      else $display("FAIL borrow_stop[%0d]: got q=%h busy=%b done=%b brw=%b, want q=%h busy=%b done=%b brw=%b",
                    k, q, busy, done, brw, e.q, e.busy, e.done, e.brw);
    end
  endtask

  task automatic test_clamp_zero();
    plan.delete();
    plan.push_back(mk(0, 1, 0, 0, 16'h9F3A, exp_of(9939, S_IDLE)));
    plan.push_back(mk(0, 1, 0, 0, 16'h0000, exp_of(0, S_IDLE)));
    plan.push_back(mk(0, 0, 1, 0, '0, exp_of(0, S_DONE)));
    plan.push_back(mk(0, 0, 0, 0, '0, exp_of(0, S_IDLE)));
    plan.push_back(mk(0, 1, 0, 0, 16'hABCD, exp_of(9999, S_IDLE)));
    foreach (plan[k]) begin
      drive(plan[k]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_total++;
      if ({q, busy, done, brw} === e) n_pass++;
      else $display("FAIL clamp_zero[%0d]: got q=%h busy=%b done=%b brw=%b, want q=%h busy=%b done=%b brw=%b",
                    k, q, busy, done, brw, e.q, e.busy, e.done, e.brw);
    end
  endtask

  task automatic test_reset_abort();
    plan.delete();
    plan.push_back(mk(0, 1, 0, 0, 16'h0003, exp_of(3, S_IDLE)));
    plan.push_back(mk(0, 0, 1, 0, '0, exp_of(3, S_RUN)));
    plan.push_back(mk(0, 0, 0, 0, '0, exp_of(2, S_RUN)));
    plan.push_back(mk(1, 0, 0, 0, '0, exp_of(0, S_IDLE)));
    plan.push_back(mk(0, 0, 0, 0, '0, exp_of(0, S_IDLE)));
    plan.push_back(mk(0, 1, 1, 0, 16'h0005, exp_of(5, S_IDLE)));
    plan.push_back(mk(0, 0, 0, 0, '0, exp_of(5, S_IDLE)));
    foreach (plan[k]) begin
      drive(plan[k]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_total++;
      if ({q, busy, done, brw} === e) n_pass++;
      else $display("FAIL reset_abort[%0d]: got q=%h busy=%b done=%b brw=%b, want q=%h busy=%b done=%b brw=%b",
                    k, q, busy, done, brw, e.q, e.busy, e.done, e.brw);
    end
  endtask

  task automatic test_auto_reload();
    int n;
    plan.delete();
    plan.push_back(mk(0, 1, 0, 0, 16'h0002, exp_of(2, S_IDLE)));
    plan.push_back(mk(0, 0, 1, 0, '0, exp_of(2, S_RUN)));
    for (int k = 1; k <= 5; k++) begin
      if (AR) begin
        n = 2 - (k % 3);
        plan.push_back(mk(0, 0, 0, 0, '0, exp_of(n, (n == 0) ? S_DONE : S_RUN)));
      end else begin
        n = (k == 1) ? 1 : 0;
        plan.push_back(mk(0, 0, 0, 0, '0, exp_of(n, (k == 1) ? S_RUN : (k == 2) ? S_DONE : S_IDLE)));
      end
    end
    plan.push_back(mk(0, 0, 0, 1, '0, exp_of(0, S_IDLE)));
    plan.push_back(mk(0, 0, 0, 0, '0, exp_of(0, S_IDLE)));
    foreach (plan[k]) begin
      drive(plan[k]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_total++;
      if ({q, busy, done, brw} === e) n_pass++;
      else $display("FAIL auto_reload[%0d]: got q=%h busy=%b done=%b brw=%b, want q=%h busy=%b done=%b brw=%b",
                    k, q, busy, done, brw, e.q, e.busy, e.done, e.brw);
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_borrow_stop();
    test_clamp_zero();
    test_reset_abort();
    test_auto_reload();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
